// File: rtl/pe_lin_ctrl.sv
// Controller for a linear PE chain: loads weights, clears accumulators, streams
// activations into PE 0, waits for the chain to drain and hands back the result vector.
module pe_lin_ctrl #(
  parameter int NPE = 4,
  parameter int AW  = 8,
  parameter int OW  = 12,
  parameter int LW  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LW-1:0]     len,
  input  logic [NPE*AW-1:0] wt_in,
  input  logic              abort,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [AW-1:0]     a_data,
  output logic              pe_fire,
  output logic [AW-1:0]     pe_a,
  output logic [NPE*AW-1:0] pe_w,
  output logic              pe_clr,
  input  logic [NPE*OW-1:0] pe_outs,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [NPE*OW-1:0] res,
  output logic              busy,
  output logic              err
);

  localparam int DW = $clog2(NPE + 2);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(NPE);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t            state_r;
  state_t            next_s;
  logic [LW-1:0]     len_r;
  logic [LW-1:0]     beat_cnt_r;
  logic [DW-1:0]     drain_cnt_r;
  logic [NPE*AW-1:0] pe_w_r;
  logic [AW-1:0]     pe_a_r;
  logic [NPE*OW-1:0] res_r;
  logic              pe_fire_r;
  logic              pe_clr_r;
  logic              a_ready_r;
  logic              res_valid_r;
  logic              busy_r;
  logic              err_r;

  logic              beat_s;
  logic              start_ok_s;
  logic              start_bad_s;
  logic              last_beat_s;
  logic              drain_end_s;
  logic              pe_clr_s;
  logic              a_ready_s;
  logic              res_valid_s;
  logic              busy_s;
  logic              err_s;

  // a_ready_r is high exactly while in STREAM; abort suppresses the beat
  assign beat_s      = a_valid && a_ready_r && !abort;
  assign start_ok_s  = (state_r == IDLE) && start && !abort && (len != {LW{1'b0}});
  assign start_bad_s = (state_r == IDLE) && start && !abort && (len == {LW{1'b0}});
  assign last_beat_s = beat_s && ((beat_cnt_r + LW'(1)) == len_r);
  assign drain_end_s = (drain_cnt_r == DRAIN_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic, abort overrides every other transition
  always_comb begin
    next_s = state_r;
    if (abort && (state_r != IDLE)) begin
      next_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    if (start_ok_s)  next_s = CLEAR;  else next_s = IDLE;
        CLEAR:   next_s = STREAM;
        STREAM:  if (last_beat_s) next_s = DRAIN;  else next_s = STREAM;
        DRAIN:   if (drain_end_s) next_s = DONE;   else next_s = DRAIN;
        DONE:    if (res_ready)   next_s = IDLE;   else next_s = DONE;
        default: next_s = IDLE;
      endcase
    end
  end

  // Output decode from the next state so the registered outputs track the state
  always_comb begin
    busy_s      = (next_s != IDLE);
    pe_clr_s    = (next_s == CLEAR);
    a_ready_s   = (next_s == STREAM);
    res_valid_s = (next_s == DONE);
    err_s       = start_bad_s;
  end

  // Registered control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r      <= 1'b0;
      pe_clr_r    <= 1'b0;
      a_ready_r   <= 1'b0;
      res_valid_r <= 1'b0;
      err_r       <= 1'b0;
      pe_fire_r   <= 1'b0;
    end else begin
      busy_r      <= busy_s;
      pe_clr_r    <= pe_clr_s;
      a_ready_r   <= a_ready_s;
      res_valid_r <= res_valid_s;
      err_r       <= err_s;
      pe_fire_r   <= beat_s;
    end
  end

  // Job parameters, activation stage and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pe_w_r <= {(NPE*AW){1'b0}};
      len_r  <= {LW{1'b0}};
      pe_a_r <= {AW{1'b0}};
      res_r  <= {(NPE*OW){1'b0}};
    end else begin
      if (start_ok_s) begin
        pe_w_r <= wt_in;
        len_r  <= len;
      end
      if (beat_s) begin
        pe_a_r <= a_data;
      end
      if ((state_r == DRAIN) && (next_s == DONE)) begin
        res_r <= pe_outs;
      end
    end
  end

  // Beat and drain counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_r  <= {LW{1'b0}};
      drain_cnt_r <= {DW{1'b0}};
    end else begin
      if (start_ok_s) begin
        beat_cnt_r <= {LW{1'b0}};
      end else if (beat_s) begin
        beat_cnt_r <= beat_cnt_r + LW'(1);
      end
      if (state_r != DRAIN) begin
        drain_cnt_r <= {DW{1'b0}};
      end else begin
        drain_cnt_r <= drain_cnt_r + DW'(1);
      end
    end
  end

  assign pe_fire   = pe_fire_r;
  assign pe_a      = pe_a_r;
  assign pe_w      = pe_w_r;
  assign pe_clr    = pe_clr_r;
  assign a_ready   = a_ready_r;
  assign res_valid = res_valid_r;
  assign res       = res_r;
  assign busy      = busy_r;
  assign err       = err_r;

endmodule

// File: tb/tb_pe_lin_ctrl.sv
// Directed self-checking bench for pe_lin_ctrl with NPE=4, AW=8, OW=12, LW=8.
module tb_pe_lin_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = 8'd0;
  logic [31:0] wt_in = 32'd0;
  logic        abort = 1'b0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [7:0]  a_data = 8'd0;
  logic        pe_fire;
  logic [7:0]  pe_a;
  logic [31:0] pe_w;
  logic        pe_clr;
  logic [47:0] pe_outs = 48'd0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [47:0] res;
  logic        busy;
  logic        err;

  int          errs = 0;
  int          checks = 0;
  logic [31:0] exp_w = 32'd0;
  logic [7:0]  exp_a = 8'd0;

  pe_lin_ctrl #(.NPE(4), .AW(8), .OW(12), .LW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .wt_in(wt_in), .abort(abort),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .pe_fire(pe_fire), .pe_a(pe_a), .pe_w(pe_w), .pe_clr(pe_clr), .pe_outs(pe_outs),
    .res_valid(res_valid), .res_ready(res_ready), .res(res), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_fire"}, pe_fire, 1'b0);
    chk({tag, "_clr"}, pe_clr, 1'b0);
    chk({tag, "_ready"}, a_ready, 1'b0);
    chk({tag, "_rv"}, res_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_pe_a"}, pe_a, 8'd0);
    chk({tag, "_pe_w"}, pe_w, 32'd0);
    chk({tag, "_res"}, res, 48'd0);
  endtask

  // Full job from IDLE: fire count/span and drain latency are hand-computed by the caller.
  task automatic run_job(input logic [7:0] n, input bit toggle, input logic [7:0] base,
                         input int exp_span, input int hold);
    int idx = 0;
    int fires = 0;
    int first_f = -1;
    int last_f = -1;
    int cyc = 0;
    int lat;
    logic exp_fire = 1'b0;
    logic exp_ready;
    logic [47:0] res_exp;
    res_exp = {6{base}};
    pe_outs = res_exp;
    exp_w = wt_in;
    start = 1'b1;
    len = n;
    @(negedge clk);
    start = 1'b0;
    chk("clr_pulse", pe_clr, 1'b1);
    chk("busy_clear", busy, 1'b1);
    chk("ready_clear", a_ready, 1'b0);
    chk("fire_clear", pe_fire, 1'b0);
    chk("pe_w_load", pe_w, exp_w);
    a_valid = 1'b1;
    a_data = base;
    exp_ready = 1'b1;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      chk("fire", pe_fire, exp_fire);
      chk("pe_a", pe_a, exp_a);
      chk("a_ready", a_ready, exp_ready);
      chk("clr_low", pe_clr, 1'b0);
      if (exp_fire) begin
        fires++;
        if (first_f < 0) first_f = cyc;
        last_f = cyc;
      end
      if (!exp_ready && !exp_fire) break;
      a_valid = toggle ? (cyc % 2 == 1) : 1'b1;
      a_data = base + idx[7:0];
      exp_fire = exp_ready && a_valid;
      if (exp_fire) begin
        exp_a = a_data;
        idx++;
        if (idx == int'(n)) exp_ready = 1'b0;
      end
    end
    a_valid = 1'b0;
    chk("fire_count", fires, n);
    chk("fire_span", last_f - first_f, exp_span);
    lat = cyc - last_f;
    while (res_valid === 1'b0 && lat < 30) begin
      chk("drain_busy", busy, 1'b1);
      chk("drain_fire", pe_fire, 1'b0);
      @(negedge clk);
      lat++;
    end
    chk("drain_lat", lat, 5);
    chk("res_valid", res_valid, 1'b1);
    chk("res", res, res_exp);
    pe_outs = ~res_exp;
    for (int i = 0; i < hold; i++) begin
      start = (i % 3 == 0);
      len = 8'd2;
      wt_in = 32'hDEADBEEF;
      @(negedge clk);
      chk("hold_rv", res_valid, 1'b1);
      chk("hold_res", res, res_exp);
      chk("hold_busy", busy, 1'b1);
      chk("hold_err", err, 1'b0);
      chk("hold_pe_w", pe_w, exp_w);
    end
    start = 1'b0;
    wt_in = exp_w;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("rv_drop", res_valid, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("res_keep", res, res_exp);
  endtask

  initial begin
    @(negedge clk);
    chk_reset_outs("rst");
    rst = 1'b0;

    // wt {1,2,3,4}, len 3, beats 5,6,7 back-to-back
    wt_in = {8'd1, 8'd2, 8'd3, 8'd4};
    run_job(8'd3, 1'b0, 8'd5, 2, 0);

    // len 0 rejected with an err pulse
    wt_in = 32'h0A0B0C0D;
    len = 8'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("len0_err", err, 1'b1);
    chk("len0_busy", busy, 1'b0);
    chk("len0_pe_w", pe_w, 32'h01020304);
    @(negedge clk);
    chk("len0_err_off", err, 1'b0);
    chk("len0_busy2", busy, 1'b0);

    // len 4 with gapped valid, then 10 cycles of backpressure in DONE
    wt_in = 32'h05060708;
    run_job(8'd4, 1'b1, 8'h20, 6, 10);

    // abort together with start in IDLE
    len = 8'd3;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abst_busy", busy, 1'b0);
    chk("abst_err", err, 1'b0);
    chk("abst_clr", pe_clr, 1'b0);

    // abort in STREAM after 2 of 5 beats
    wt_in = 32'h11223344;
    len = 8'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ab_busy", busy, 1'b1);
    a_valid = 1'b1;
    a_data = 8'd10;
    @(negedge clk);
    chk("ab_ready", a_ready, 1'b1);
    @(negedge clk);
    chk("ab_fire1", pe_fire, 1'b1);
    chk("ab_a1", pe_a, 8'd10);
    a_data = 8'd11;
    @(negedge clk);
    chk("ab_fire2", pe_fire, 1'b1);
    chk("ab_a2", pe_a, 8'd11);
    abort = 1'b1;
    a_data = 8'd12;
    @(negedge clk);
    abort = 1'b0;
    a_valid = 1'b0;
    chk("ab_idle_busy", busy, 1'b0);
    chk("ab_ready0", a_ready, 1'b0);
    chk("ab_fire0", pe_fire, 1'b0);
    chk("ab_a_hold", pe_a, 8'd11);
    chk("ab_pe_w", pe_w, 32'h11223344);
    exp_a = 8'd11;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("ab_no_rv", res_valid, 1'b0);
    end
    run_job(8'd1, 1'b0, 8'h40, 0, 2);

    // async reset mid-DRAIN
    wt_in = 32'h99887766;
    len = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_valid = 1'b1;
    a_data = 8'h77;
    @(negedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    chk("mr_fire", pe_fire, 1'b1);
    @(negedge clk);
    chk("mr_drain_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1 chk_reset_outs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    exp_a = 8'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_rv", res_valid, 1'b0);
      chk("post_rst_busy", busy, 1'b0);
    end

    // first edge after reset release accepts start
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wt_in = 32'hA1B2C3D4;
    run_job(8'd2, 1'b0, 8'h50, 1, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
